reg_wb: RTL and testbench

REG_WB -- requirements
Module: reg_wb

---
 rtl/reg_wb_if.sv | 30 +++
 rtl/reg_wb.sv | 102 ++++++++++
 tb/tb_reg_wb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_if.sv
// Writeback bus between the result producer and reg_wb, including the
// register-file write port and the pending-write hazard query.
interface reg_wb_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_regwen;
   logic [31:0] in_data;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic [1:0]  in_byte_off;
   logic        wb_stall;
   logic        RegWEn;
   logic [4:0]  rsW;
   logic [31:0] dataW;
   logic [4:0]  query_rs;
   logic        query_hit;

   modport master (
      output in_valid, in_rd, in_regwen, in_data, in_is_load, in_funct3,
             in_byte_off, wb_stall, query_rs,
      input  in_ready, RegWEn, rsW, dataW, query_hit
   );

   modport slave (
      input  in_valid, in_rd, in_regwen, in_data, in_is_load, in_funct3,
             in_byte_off, wb_stall, query_rs,
      output in_ready, RegWEn, rsW, dataW, query_hit
   );
endinterface

// File: rtl/reg_wb.sv
// Writeback stage: 2-entry result FIFO with load formatting at push, a
// registered register-file write port, and a pending-write hazard query.
module reg_wb (
   input  logic      clk,
   input  logic      rst_n,
   reg_wb_if.slave   bus
);
   typedef struct packed {
      logic [4:0]  rd;
      logic        regwen;
      logic [31:0] data;
   } wb_entry_t;

   // slot 0 is always the head; a pop shifts slot 1 down
   wb_entry_t [1:0] slot_q, slot_d;
   logic [1:0]      count_q, count_d;
   logic            regwen_q, regwen_d;
   logic [4:0]      rsw_q, rsw_d;
   logic [31:0]     dataw_q, dataw_d;

   logic            push, pop, wr_idx;
   logic [1:0]      slot_vld;
   logic [31:0]     shifted;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [31:0]     fmt_data;
   logic            hit;

   assign bus.in_ready = (count_q != 2'd2);
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = !bus.wb_stall && (count_q != 2'd0);
   assign wr_idx       = count_q[0] & ~pop;
   assign slot_vld     = {count_q == 2'd2, count_q != 2'd0};

   always_comb begin
      shifted  = bus.in_data >> {bus.in_byte_off, 3'b000};
      ld_byte  = shifted[7:0];
      ld_half  = bus.in_byte_off[1] ? bus.in_data[31:16] : bus.in_data[15:0];
      fmt_data = bus.in_data;
      if (bus.in_is_load) begin
         case (bus.in_funct3)
            3'b000:  fmt_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  fmt_data = {24'd0, ld_byte};
            3'b001:  fmt_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  fmt_data = {16'd0, ld_half};
            default: fmt_data = bus.in_data;
         endcase
      end
   end

   always_comb begin
      slot_d   = slot_q;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      regwen_d = 1'b0;
      rsw_d    = rsw_q;
      dataw_d  = dataw_q;
      if (pop) begin
         regwen_d  = slot_q[0].regwen && (slot_q[0].rd != 5'd0);
         rsw_d     = slot_q[0].rd;
         dataw_d   = slot_q[0].data;
         slot_d[0] = slot_q[1];
      end
      if (push) begin
         slot_d[wr_idx].rd     = bus.in_rd;
         slot_d[wr_idx].regwen = bus.in_regwen;
         slot_d[wr_idx].data   = fmt_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q   <= '0;
         count_q  <= 2'd0;
         regwen_q <= 1'b0;
         rsw_q    <= 5'd0;
         dataw_q  <= 32'd0;
      end else begin
         slot_q   <= slot_d;
         count_q  <= count_d;
         regwen_q <= regwen_d;
         rsw_q    <= rsw_d;
         dataw_q  <= dataw_d;
      end
   end

   // x0 is never a hazard; both buffered entries and the output stage count
   always_comb begin
      hit = 1'b0;
      if (bus.query_rs != 5'd0) begin
         for (int i = 0; i < 2; i++)
            if (slot_vld[i] && slot_q[i].regwen && slot_q[i].rd == bus.query_rs)
               hit = 1'b1;
         if (regwen_q && rsw_q == bus.query_rs)
            hit = 1'b1;
      end
   end

   assign bus.query_hit = hit;
   assign bus.RegWEn    = regwen_q;
   assign bus.rsW       = rsw_q;
   assign bus.dataW     = dataw_q;
endmodule

// File: tb/tb_reg_wb.sv
// Directed bench for reg_wb: reset, ALU and load writeback, x0 handling,
// stall backpressure, mid-operation reset and back-to-back writes.
module tb_reg_wb;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   reg_wb_if bus ();

   reg_wb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                        input logic [31:0] d, input logic ld,
                        input logic [2:0] f3, input logic [1:0] off);
      bus.in_valid    = v;
      bus.in_rd       = rd;
      bus.in_regwen   = we;
      bus.in_data     = d;
      bus.in_is_load  = ld;
      bus.in_funct3   = f3;
      bus.in_byte_off = off;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 2'd0);
      bus.wb_stall = 1'b0;
      bus.query_rs = 5'd3;
      #2;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.RegWEn !== 1'b0) begin n_err++; $display("FAIL reset_regwen: got %b want 0", bus.RegWEn); end
      n_cmp++; if (bus.rsW !== 5'd0) begin n_err++; $display("FAIL reset_rsw: got %0d want 0", bus.rsW); end
      n_cmp++; if (bus.dataW !== 32'd0) begin n_err++; $display("FAIL reset_dataw: got %h want 0", bus.dataW); end
      n_cmp++; if (bus.query_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", bus.query_hit); end
      #10 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alu;
      bus.query_rs = 5'd3;
      drive(1'b1, 5'd3, 1'b1, 32'd55, 1'b0, 3'd0, 2'd0);
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b want 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.RegWEn !== 1'b0) begin n_err++; $display("FAIL alu_early_we: got %b want 0", bus.RegWEn); end
      n_cmp++; if (bus.query_hit !== 1'b1) begin n_err++; $display("FAIL alu_hit_fifo: got %b want 1", bus.query_hit); end
      tick();
      n_cmp++; if (bus.RegWEn !== 1'b1) begin n_err++; $display("FAIL alu_we: got %b want 1", bus.RegWEn); end
      n_cmp++; if (bus.rsW !== 5'd3) begin n_err++; $display("FAIL alu_rsw: got %0d want 3", bus.rsW); end
      n_cmp++; if (bus.dataW !== 32'd55) begin n_err++; $display("FAIL alu_dataw: got %0d want 55", bus.dataW); end
      n_cmp++; if (bus.query_hit !== 1'b1) begin n_err++; $display("FAIL alu_hit_out: got %b want 1", bus.query_hit); end
      tick();
      n_cmp++; if (bus.RegWEn !== 1'b0) begin n_err++; $display("FAIL alu_we_drop: got %b want 0", bus.RegWEn); end
      n_cmp++; if (bus.query_hit !== 1'b0) begin n_err++; $display("FAIL alu_hit_clear: got %b want 0", bus.query_hit); end
      n_cmp++; if (bus.dataW !== 32'd55) begin n_err++; $display("FAIL alu_dataw_hold: got %0d want 55", bus.dataW); end
   endtask

   task automatic test_load;
      logic [2:0]  f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b000};
      logic [1:0]  off [7] = '{2'd2,   2'd1,   2'd2,   2'd0,   2'd3,   2'd1,   2'd1};
      logic        ld  [7] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
      logic [31:0] exp [7] = '{32'hFFFFFFFF, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                               32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 5'd9, 1'b1, 32'h80FF7F01, ld[i], f3[i], off[i]);
         tick();
         bus.in_valid = 1'b0;
         tick();
         n_cmp++;
         if (bus.dataW !== exp[i]) begin
            n_err++;
            $display("FAIL load_%0d f3=%b off=%0d: got %h want %h", i, f3[i], off[i], bus.dataW, exp[i]);
         end
      end
      tick();
   endtask

   task automatic test_rd0;
      bus.query_rs = 5'd0;
      drive(1'b1, 5'd0, 1'b1, 32'd123, 1'b0, 3'd0, 2'd0);
      tick();
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.query_hit !== 1'b0) begin n_err++; $display("FAIL rd0_hit: got %b want 0", bus.query_hit); end
      tick();
      n_cmp++; if (bus.RegWEn !== 1'b0) begin n_err++; $display("FAIL rd0_we: got %b want 0", bus.RegWEn); end
      n_cmp++; if (bus.dataW !== 32'd123) begin n_err++; $display("FAIL rd0_pop_data: got %0d want 123", bus.dataW); end
      n_cmp++; if (bus.query_hit !== 1'b0) begin n_err++; $display("FAIL rd0_hit_out: got %b want 0", bus.query_hit); end
      bus.query_rs = 5'd7;
      drive(1'b1, 5'd7, 1'b0, 32'd77, 1'b0, 3'd0, 2'd0);
      tick();
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.query_hit !== 1'b0) begin n_err++; $display("FAIL nowen_hit: got %b want 0", bus.query_hit); end
      tick();
      n_cmp++; if (bus.RegWEn !== 1'b0) begin n_err++; $display("FAIL nowen_we: got %b want 0", bus.RegWEn); end
      n_cmp++; if (bus.rsW !== 5'd7) begin n_err++; $display("FAIL nowen_rsw: got %0d want 7", bus.rsW); end
      tick();
   endtask

   task automatic test_stall;
      bus.wb_stall = 1'b1;
      bus.query_rs = 5'd12;
      drive(1'b1, 5'd10, 1'b1, 32'd100, 1'b0, 3'd0, 2'd0);
      tick();
      drive(1'b1, 5'd11, 1'b1, 32'd101, 1'b0, 3'd0, 2'd0);
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready1: got %b want 1", bus.in_ready); end
      tick();
      drive(1'b1, 5'd12, 1'b1, 32'd102, 1'b0, 3'd0, 2'd0);
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_full: got %b want 0", bus.in_ready); end
      tick();
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_still_full: got %b want 0", bus.in_ready); end
      n_cmp++; if (bus.RegWEn !== 1'b0) begin n_err++; $display("FAIL stall_we: got %b want 0", bus.RegWEn); end
      n_cmp++; if (bus.query_hit !== 1'b0) begin n_err++; $display("FAIL stall_hit_c: got %b want 0", bus.query_hit); end
      bus.wb_stall = 1'b0;
      tick();
      n_cmp++; if (bus.RegWEn !== 1'b1 || bus.rsW !== 5'd10 || bus.dataW !== 32'd100) begin n_err++; $display("FAIL stall_w0: got we=%b rd=%0d d=%0d want 1/10/100", bus.RegWEn, bus.rsW, bus.dataW); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready_again: got %b want 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.RegWEn !== 1'b1 || bus.rsW !== 5'd11 || bus.dataW !== 32'd101) begin n_err++; $display("FAIL stall_w1: got we=%b rd=%0d d=%0d want 1/11/101", bus.RegWEn, bus.rsW, bus.dataW); end
      n_cmp++; if (bus.query_hit !== 1'b1) begin n_err++; $display("FAIL stall_hit_c_acc: got %b want 1", bus.query_hit); end
      tick();
      n_cmp++; if (bus.RegWEn !== 1'b1 || bus.rsW !== 5'd12 || bus.dataW !== 32'd102) begin n_err++; $display("FAIL stall_w2: got we=%b rd=%0d d=%0d want 1/12/102", bus.RegWEn, bus.rsW, bus.dataW); end
      tick();
      n_cmp++; if (bus.RegWEn !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", bus.RegWEn); end
   endtask

   task automatic test_reset_mid;
      bus.query_rs = 5'd20;
      drive(1'b1, 5'd19, 1'b1, 32'd190, 1'b0, 3'd0, 2'd0);
      tick();
      drive(1'b1, 5'd20, 1'b1, 32'd200, 1'b0, 3'd0, 2'd0);
      tick();
      bus.wb_stall = 1'b1;
      drive(1'b1, 5'd21, 1'b1, 32'd210, 1'b0, 3'd0, 2'd0);
      tick();
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_full: got %b want 0", bus.in_ready); end
      n_cmp++; if (bus.query_hit !== 1'b1) begin n_err++; $display("FAIL rmid_hit_pre: got %b want 1", bus.query_hit); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.RegWEn !== 1'b0) begin n_err++; $display("FAIL rmid_we: got %b want 0", bus.RegWEn); end
      n_cmp++; if (bus.rsW !== 5'd0 || bus.dataW !== 32'd0) begin n_err++; $display("FAIL rmid_out: got rd=%0d d=%0d want 0/0", bus.rsW, bus.dataW); end
      n_cmp++; if (bus.query_hit !== 1'b0) begin n_err++; $display("FAIL rmid_hit: got %b want 0", bus.query_hit); end
      #1 rst_n = 1'b1;
      bus.wb_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (bus.RegWEn !== 1'b0) begin n_err++; $display("FAIL rmid_no_write_%0d: got %b want 0", i, bus.RegWEn); end
      end
   endtask

   task automatic test_back_to_back;
      drive(1'b1, 5'd5, 1'b1, 32'h55, 1'b0, 3'd0, 2'd0);
      tick();
      drive(1'b1, 5'd6, 1'b1, 32'h66, 1'b0, 3'd0, 2'd0);
      tick();
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.RegWEn !== 1'b1 || bus.rsW !== 5'd5 || bus.dataW !== 32'h55) begin n_err++; $display("FAIL b2b_w0: got we=%b rd=%0d d=%h want 1/5/55", bus.RegWEn, bus.rsW, bus.dataW); end
      tick();
      n_cmp++; if (bus.RegWEn !== 1'b1 || bus.rsW !== 5'd6 || bus.dataW !== 32'h66) begin n_err++; $display("FAIL b2b_w1: got we=%b rd=%0d d=%h want 1/6/66", bus.RegWEn, bus.rsW, bus.dataW); end
      tick();
      n_cmp++; if (bus.RegWEn !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", bus.RegWEn); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_alu();
      test_load();
      test_rd0();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
